// File: rtl/rvfpm_result_arbiter_pkg.sv
// rvfpm_result_arbiter_pkg: shared types, widths and pick helper for the XIF result arbiter
`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef FLEN
`define FLEN 32
`endif
package rvfpm_result_arbiter_pkg;
  localparam int RD_WIDTH = 5;
  localparam int X_ID_WIDTH_DEF = `X_ID_WIDTH;
  localparam int FLEN_DEF = `FLEN;
  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;
  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0] id;
    logic [FLEN_DEF-1:0] data;
    logic [RD_WIDTH-1:0] rd;
    logic we;
  } rvfpm_res_entry_t;
  function automatic logic [2:0] lowest8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/rvfpm_result_arbiter_rr.sv
// rvfpm_rr_arbiter: mask-based round-robin pick, fixed lowest-index priority under RVFPM_ARB_FIXED_PRIO_EN
module rvfpm_rr_arbiter
  import rvfpm_result_arbiter_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [7:0] req8, msk8;
  logic [2:0] pick;
  // requests at or above ptr win first; fall back to the full set on wrap
  always_comb begin
    req8 = 8'(req);
`ifdef RVFPM_ARB_FIXED_PRIO_EN
    msk8 = req8;
`else
    msk8 = req8 & (8'hFF << ptr);
`endif
    pick = lowest8(|msk8 ? msk8 : req8);
    idx = IW'(pick);
    gnt = N'(|req) << pick;
  end
endmodule

// File: rtl/rvfpm_result_arbiter.sv
// rvfpm_result_arbiter: shares the XIF result port between NUM_SRC producers (RVFPM_ARB_FIXED_PRIO_EN: fixed priority)
module rvfpm_result_arbiter
  import rvfpm_result_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int X_ID_WIDTH = `X_ID_WIDTH,
  parameter int FLEN = `FLEN,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic                           ck,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid,
  output logic [NUM_SRC-1:0]             src_ready,
  input  logic [NUM_SRC*X_ID_WIDTH-1:0]  src_id,
  input  logic [NUM_SRC*FLEN-1:0]        src_data,
  input  logic [NUM_SRC*RD_WIDTH-1:0]    src_rd,
  input  logic [NUM_SRC-1:0]             src_we,
  input  logic                           commit_valid,
  input  logic [X_ID_WIDTH-1:0]          commit_id,
  input  logic                           commit_kill,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic [X_ID_WIDTH-1:0]          result_id,
  output logic [FLEN-1:0]                result_data,
  output logic [RD_WIDTH-1:0]            result_rd,
  output logic                           result_we,
  output logic [IW-1:0]                  grant_idx,
  output logic                           busy
);
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0] data;
    logic [RD_WIDTH-1:0] rd;
    logic we;
  } entry_t;
  entry_t src_e [NUM_SRC];
  entry_t ent_q [NUM_SRC];
  entry_t res_q;
  logic [NUM_SRC-1:0] buf_v, kill, cap, elig, gnt;
  logic [IW-1:0] win, rr;
  logic kill_hit, do_load;
  arb_state_e state, state_nx;
  // unpack sources, resolve kills against buffers and same-edge captures
  always_comb begin
    kill_hit = commit_valid && commit_kill;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_e[i] = {src_id[i*X_ID_WIDTH +: X_ID_WIDTH], src_data[i*FLEN +: FLEN],
                  src_rd[i*RD_WIDTH +: RD_WIDTH], src_we[i]};
      kill[i] = kill_hit && ent_q[i].id == commit_id;
      cap[i] = src_valid[i] && !buf_v[i] && !(kill_hit && src_e[i].id == commit_id);
    end
    elig = buf_v & ~kill;
  end
  rvfpm_rr_arbiter #(.N(NUM_SRC)) u_pick (
    .req(elig),
    .ptr(rr),
    .gnt(gnt),
    .idx(win)
  );
  // next state: load whenever the output slot is free or being accepted
  always_comb begin
    do_load = (state == ARB_IDLE || result_ready) && |elig;
    state_nx = do_load ? ARB_HOLD : (result_ready ? ARB_IDLE : state);
  end
  // state register
  always_ff @(posedge ck)
    if (rst) state <= ARB_IDLE;
    else state <= state_nx;
  // buffer valids: capture, kill and drain
  always_ff @(posedge ck)
    if (rst) buf_v <= '0;
    else buf_v <= cap | (buf_v & ~kill & ~(do_load ? gnt : '0));
  // buffer payloads follow captures only
  always_ff @(posedge ck)
    for (int i = 0; i < NUM_SRC; i++) if (cap[i]) ent_q[i] <= src_e[i];
  // output register, grant index and rr pointer update on each load
  always_ff @(posedge ck)
    if (rst) begin
      res_q <= '0;
      grant_idx <= '0;
      rr <= '0;
    end else if (do_load) begin
      res_q <= ent_q[win];
      grant_idx <= win;
`ifdef RVFPM_ARB_FIXED_PRIO_EN
      rr <= '0;
`else
      rr <= (win == IW'(NUM_SRC - 1)) ? '0 : win + 1'b1;
`endif
    end
  assign src_ready = ~buf_v;
  assign result_valid = state == ARB_HOLD;
  assign result_id = res_q.id;
  assign result_data = res_q.data;
  assign result_rd = res_q.rd;
  assign result_we = res_q.we;
  assign busy = |buf_v || result_valid;
endmodule
